uio_bus_arbiter: RTL and testbench

//   Shares the 8-bit bidirectional uio pad bank of the tt_um_DanielZhu123 top

---
 rtl/uio_bus_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_uio_bus_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/uio_bus_arbiter.sv
// Round-robin owner of the shared 8-bit uio pad bank among NREQ requesters.
// Latency: req sampled in IDLE -> gnt high TURN_CYC edges later; pads registered.
// Backpressure: level req/gnt handshake; owner holds req, loses gnt on drop, ena low or burst cap.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   ena             design enable; low blocks new grants and aborts TURN/OWN
//   req, dir        per-requester level request and direction (1=drive, 0=read)
//   wdata           per-requester write byte, slice [8i+7:8i]
//   uio_in          pad input path
//   gnt             one-hot registered grant
//   uio_out, uio_oe registered pad output data and enable (oe is 8'h00 or 8'hFF)
//   rdata, rd_valid registered pad sample and its valid
//   busy            arbiter not in IDLE
module uio_bus_arbiter #(
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 8,
  parameter int TURN_CYC  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   dir,
  input  logic [NREQ*8-1:0] wdata,
  input  logic [7:0]        uio_in,
  output logic [NREQ-1:0]   gnt,
  output logic [7:0]        uio_out,
  output logic [7:0]        uio_oe,
  output logic [7:0]        rdata,
  output logic              rd_valid,
  output logic              busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int TW = $clog2(TURN_CYC + 1);

  // burst counter holds (cycles gnt has been high - 1) while in OWN
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic [TW-1:0] TURN_LAST  = TW'(TURN_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TURN = 2'd1,
    ST_OWN  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     own_q, own_d;
  logic              wdir_q, wdir_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [7:0]        out_q, out_d;
  logic [7:0]        oe_q, oe_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              rdv_q, rdv_d;
  logic [BW-1:0]     burst_q, burst_d;
  logic [TW-1:0]     turn_q, turn_d;

  logic              win_found;
  logic [PW-1:0]     win_idx;
  logic              own_exit;

  // (base + off) mod NREQ, off in [0, NREQ)
  function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return s[PW-1:0];
  endfunction

  // First requester at or after ptr, wrapping; order depends only on ptr.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!win_found && req[rr_idx(ptr_q, i)]) begin
        win_found = 1'b1;
        win_idx   = rr_idx(ptr_q, i);
      end
    end
  end

  assign own_exit = !ena || !req[own_q] || (burst_q == BURST_LAST);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    wdir_d  = wdir_q;
    gnt_d   = gnt_q;
    out_d   = out_q;
    oe_d    = oe_q;
    rdata_d = rdata_q;
    rdv_d   = 1'b0;
    burst_d = burst_q;
    turn_d  = turn_q;

    case (state_q)
      ST_IDLE: begin
        if (ena && win_found) begin
          own_d   = win_idx;
          wdir_d  = dir[win_idx];
          turn_d  = '0;
          state_d = ST_TURN;
        end
      end

      ST_TURN: begin
        if (!ena || !req[own_q]) begin
          // abort without touching ptr: the same requester keeps its turn
          state_d = ST_IDLE;
        end else if (turn_q == TURN_LAST) begin
          state_d = ST_OWN;
          gnt_d   = NREQ'(1) << own_q;
          burst_d = '0;
          if (wdir_q) begin
            oe_d  = 8'hFF;
            out_d = wdata[{own_q, 3'b000} +: 8];
          end
        end else begin
          turn_d = turn_q + TW'(1);
        end
      end

      ST_OWN: begin
        if (own_exit) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          oe_d    = 8'h00;
          out_d   = 8'h00;
          ptr_d   = rr_idx(own_q, 1);
        end else begin
          // never reaches MAX_BURST here, so the counter cannot wrap
          burst_d = burst_q + BW'(1);
          if (wdir_q) begin
            out_d = wdata[{own_q, 3'b000} +: 8];
          end else begin
            rdata_d = uio_in;
            rdv_d   = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        oe_d    = 8'h00;
        out_d   = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      own_q   <= '0;
      wdir_q  <= 1'b0;
      gnt_q   <= '0;
      out_q   <= 8'h00;
      oe_q    <= 8'h00;
      rdata_q <= 8'h00;
      rdv_q   <= 1'b0;
      burst_q <= '0;
      turn_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      wdir_q  <= wdir_d;
      gnt_q   <= gnt_d;
      out_q   <= out_d;
      oe_q    <= oe_d;
      rdata_q <= rdata_d;
      rdv_q   <= rdv_d;
      burst_q <= burst_d;
      turn_q  <= turn_d;
    end
  end

  assign gnt      = gnt_q;
  assign uio_out  = out_q;
  assign uio_oe   = oe_q;
  assign rdata    = rdata_q;
  assign rd_valid = rdv_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Bench for uio_bus_arbiter: directed stimulus pushes expected grants and read
// samples into queues; a monitor pops and compares as the DUT presents them.
module tb_uio_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic [3:0]  req;
  logic [3:0]  dir;
  logic [31:0] wdata;
  logic [7:0]  uio_in;
  logic [3:0]  gnt;
  logic [7:0]  uio_out;
  logic [7:0]  uio_oe;
  logic [7:0]  rdata;
  logic        rd_valid;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] g;
    logic [7:0] oe;
    logic [7:0] dout;
    int         len;
    int         gap;   // -1: previous cycle history not checked
  } grant_t;

  grant_t     gq[$];
  logic [7:0] rq[$];

  uio_bus_arbiter #(.NREQ(4), .MAX_BURST(8), .TURN_CYC(1)) dut (
    .clk(clk), .rst(rst), .ena(ena), .req(req), .dir(dir), .wdata(wdata),
    .uio_in(uio_in), .gnt(gnt), .uio_out(uio_out), .uio_oe(uio_oe),
    .rdata(rdata), .rd_valid(rd_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    logic [3:0] prev_gnt;
    int         cur_len;
    int         gap_cnt;
    grant_t     cur;
    prev_gnt = '0;
    cur_len  = 0;
    gap_cnt  = 0;
    cur      = '{4'b0, 8'h0, 8'h0, 0, -1};
    forever begin
      @(posedge clk);
      #1;
      chk("gnt_onehot0", {31'b0, $onehot0(gnt)}, 32'd1);
      chk("oe_legal", {31'b0, (uio_oe == 8'h00 || uio_oe == 8'hFF)}, 32'd1);
      if (gnt == 4'b0) chk("oe_without_gnt", {24'b0, uio_oe}, 32'h0);
      if (rd_valid) begin
        if (rq.size() == 0) chk("rd_unexpected", {24'b0, rdata}, 32'hFFFF_FFFF);
        else chk("rdata", {24'b0, rdata}, {24'b0, rq.pop_front()});
      end
      if (gnt != prev_gnt) begin
        if (prev_gnt != 4'b0) begin
          chk("grant_len", cur_len, cur.len);
          chk("release_gnt", {28'b0, gnt}, 32'h0);
          chk("release_out", {24'b0, uio_out}, 32'h0);
          gap_cnt = 0;
        end
        if (gnt != 4'b0) begin
          if (gq.size() == 0) begin
            chk("grant_unexpected", {28'b0, gnt}, 32'h0);
            cur = '{gnt, uio_oe, uio_out, 0, -1};
          end else begin
            cur = gq.pop_front();
            chk("grant_gnt", {28'b0, gnt}, {28'b0, cur.g});
            chk("grant_oe", {24'b0, uio_oe}, {24'b0, cur.oe});
            chk("grant_out", {24'b0, uio_out}, {24'b0, cur.dout});
            if (cur.gap >= 0) chk("handover_gap", gap_cnt, cur.gap);
          end
          cur_len = 0;
        end
      end
      if (gnt != 4'b0) cur_len++;
      else gap_cnt++;
      prev_gnt = gnt;
    end
  end

  initial begin
    rst = 1'b1; ena = 1'b1; req = '0; dir = '0; wdata = '0; uio_in = '0;
    wait_neg(2);
    chk("rst_gnt", {28'b0, gnt}, 32'h0);
    chk("rst_oe", {24'b0, uio_oe}, 32'h0);
    chk("rst_out", {24'b0, uio_out}, 32'h0);
    chk("rst_rdata", {24'b0, rdata}, 32'h0);
    chk("rst_rdv", {31'b0, rd_valid}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    rst = 1'b0;
    wait_neg(2);

    // 1: single write grant, two-edge latency, release on req drop
    gq.push_back('{4'b0010, 8'hFF, 8'hA5, 4, -1});
    req = 4'b0010; dir = 4'b0010; wdata = 32'h0000_A500;
    wait_neg(1);
    chk("t1_turn_gnt", {28'b0, gnt}, 32'h0);
    chk("t1_turn_oe", {24'b0, uio_oe}, 32'h0);
    chk("t1_turn_busy", {31'b0, busy}, 32'h1);
    wait_neg(1);
    chk("t1_gnt", {28'b0, gnt}, 32'h2);
    wait_neg(3);
    req = 4'b0000;
    wait_neg(1);
    chk("t1_drop_gnt", {28'b0, gnt}, 32'h0);
    chk("t1_drop_oe", {24'b0, uio_oe}, 32'h0);
    wait_neg(3);

    // 2: all request from ptr=0: rotation 0,1,2,3,0 with 8-cycle bursts
    rst = 1'b1;
    wait_neg(1);
    rst = 1'b0;
    gq.push_back('{4'b0001, 8'hFF, 8'h11, 8, -1});
    gq.push_back('{4'b0010, 8'hFF, 8'h22, 8, 2});
    gq.push_back('{4'b0100, 8'hFF, 8'h33, 8, 2});
    gq.push_back('{4'b1000, 8'hFF, 8'h44, 8, 2});
    gq.push_back('{4'b0001, 8'hFF, 8'h11, 4, 2});
    req = 4'b1111; dir = 4'b1111; wdata = 32'h4433_2211;
    wait_neg(45);
    req = 4'b0000;
    wait_neg(4);

    // 3: read grant to requester 2 (ptr=1)
    gq.push_back('{4'b0100, 8'h00, 8'h00, 4, -1});
    rq.push_back(8'h3C); rq.push_back(8'h5A); rq.push_back(8'h5A);
    req = 4'b0100; dir = 4'b0000; uio_in = 8'h3C;
    wait_neg(3);
    uio_in = 8'h5A;
    wait_neg(2);
    req = 4'b0000;
    wait_neg(4);

    // 4: ena drop mid-OWN (ptr=3 -> owner 3), then next grant goes to 0
    gq.push_back('{4'b1000, 8'hFF, 8'h44, 3, -1});
    gq.push_back('{4'b0001, 8'hFF, 8'h11, 5, -1});
    req = 4'b1001; dir = 4'b1111; wdata = 32'h4433_2211;
    wait_neg(4);
    ena = 1'b0;
    wait_neg(6);
    chk("t4_ena_low_busy", {31'b0, busy}, 32'h0);
    ena = 1'b1;
    wait_neg(6);
    req = 4'b0000;
    wait_neg(4);

    // 5: abort in TURN keeps ptr=1; then async reset while owner 1 drives
    req = 4'b1000;
    wait_neg(1);
    req = 4'b0000;
    wait_neg(1);
    chk("t5_abort_busy", {31'b0, busy}, 32'h0);
    chk("t5_abort_gnt", {28'b0, gnt}, 32'h0);
    wait_neg(2);
    gq.push_back('{4'b0010, 8'hFF, 8'h22, 3, -1});
    req = 4'b0011;
    wait_neg(4);
    #2 rst = 1'b1;
    #1;
    chk("t5_arst_gnt", {28'b0, gnt}, 32'h0);
    chk("t5_arst_oe", {24'b0, uio_oe}, 32'h0);
    chk("t5_arst_out", {24'b0, uio_out}, 32'h0);
    chk("t5_arst_busy", {31'b0, busy}, 32'h0);
    wait_neg(1);
    rst = 1'b0; req = 4'b0000;
    wait_neg(3);

    // 6: sole requester capped, re-wins after IDLE + TURN
    gq.push_back('{4'b0001, 8'hFF, 8'h11, 8, -1});
    gq.push_back('{4'b0001, 8'hFF, 8'h11, 4, 2});
    req = 4'b0001; dir = 4'b0001;
    wait_neg(15);
    req = 4'b0000;
    wait_neg(5);

    chk("grants_left", gq.size(), 32'h0);
    chk("reads_left", rq.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
